// File: rtl/nn_pkg.sv
// Shared constants for the 1-input neural net.
// The forward net and its inverse search both build f(x) from these constants.
package nn_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, DONE = 2'd2} nn_state_t;

  localparam int NN_H1_W = 2;
  localparam int NN_H1_B = 10;
  localparam int NN_H2_W = 1;
  localparam int NN_H2_B = 20;
  localparam int NN_O_W1 = 1;
  localparam int NN_O_W2 = 2;
  localparam int NN_O_B  = 5;
  localparam int NN_SAT  = 255;

  // Clamp a 10-bit pre-activation to the 8-bit output range
  function automatic logic [7:0] sat255(input logic [9:0] v);
    return (v > 10'(NN_SAT)) ? 8'(NN_SAT) : v[7:0];
  endfunction
endpackage

// File: rtl/nn_forward_eval.sv
// Combinational forward evaluation of the net: x -> f(x).
// Every intermediate is 10 bits wide so saturation never sees a wrapped value.
module nn_forward_eval
  import nn_pkg::*;
(
  input  logic [7:0] x,
  output logic [7:0] f
);
  logic [9:0] h1_raw, h2_raw, o_raw;
  logic [7:0] h1, h2;

  assign h1_raw = 10'(NN_H1_W) * {2'b00, x} + 10'(NN_H1_B);
  assign h2_raw = 10'(NN_H2_W) * {2'b00, x} + 10'(NN_H2_B);
  assign h1     = sat255(h1_raw);
  assign h2     = sat255(h2_raw);
  assign o_raw  = 10'(NN_O_W1) * {2'b00, h1} + 10'(NN_O_W2) * {2'b00, h2} + 10'(NN_O_B);
  assign f      = sat255(o_raw);
endmodule

// File: rtl/nn_inverse_search.sv
// Finds the smallest x with f(x) >= target by an 8-step binary search,
// one forward evaluation per cycle, with valid/ready handshakes on both sides.
module nn_inverse_search
  import nn_pkg::*;
#(
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] target,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] x_out,
  output logic [7:0] f_out,
  output logic       exact
);
  localparam int ITERS = W;

  nn_state_t  state;
  logic [7:0] lo, hi, tgt;
  logic [3:0] cnt;
  logic [8:0] sum;
  logic [7:0] mid, f_mid, lo_nxt, hi_nxt, f_fin;
  logic       ge;

  assign sum    = {1'b0, lo} + {1'b0, hi};
  assign mid    = sum[8:1];
  assign ge     = (f_mid >= tgt);
  // mid < hi whenever lo < hi, so mid+1 cannot overflow
  assign lo_nxt = ge ? lo : mid + 8'd1;
  assign hi_nxt = ge ? mid : hi;

  // Second evaluator scores the converged x so f_out lands with out_valid
  nn_forward_eval u_eval_mid (.x(mid),    .f(f_mid));
  nn_forward_eval u_eval_fin (.x(lo_nxt), .f(f_fin));

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      x_out     <= 8'd0;
      f_out     <= 8'd0;
      exact     <= 1'b0;
      lo        <= 8'd0;
      hi        <= 8'd255;
      cnt       <= 4'd0;
      tgt       <= 8'd0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          tgt   <= target;
          lo    <= 8'd0;
          hi    <= 8'd255;
          cnt   <= 4'd0;
          state <= SEARCH;
        end
        SEARCH: begin
          lo  <= lo_nxt;
          hi  <= hi_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'(ITERS - 1)) begin
            state     <= DONE;
            x_out     <= lo_nxt;
            f_out     <= f_fin;
            exact     <= (f_fin == tgt);
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
